alu_div_restoring: RTL

Multi-cycle unsigned restoring divider in the ALU's execute stage. It sits directly downstream of the 1-bit full-subtractor cell `fs_1bit`. A ripple-borrow chain of those cells forms the trial subtraction. One quotient bit is produced per clock, and a start/done handshake lets the pipeline control stall EX while a divide is in flight.

---
 rtl/alu_div_restoring_pkg.sv | 12 +
 rtl/alu_div_restoring_if.sv | 21 ++
 rtl/alu_div_restoring_sub.sv | 33 +++
 rtl/alu_div_restoring.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_div_restoring_pkg.sv
// Shared definitions for the ALU execute-stage divider: FSM state encoding and default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_div_restoring_if.sv
// Start/done handshake and operand/result bundle between EX control and the divider.
interface alu_div_restoring_if #(parameter int WIDTH = alu_pkg::DEFAULT_WIDTH);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_div_restoring_sub.sv
// Ripple-borrow subtractor built from 1-bit full-subtractor cells; diff = a - b, bout = final borrow.
module fs_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);
endmodule

module sub_nbit #(parameter int WIDTH = 33) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  logic [WIDTH:0] borrow_s;

  assign borrow_s[0] = 1'b0;
  assign bout        = borrow_s[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_1bit u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow_s[i]),
      .diff (diff[i]),
      .bout (borrow_s[i+1])
    );
  end
endmodule

// File: rtl/alu_div_restoring.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake for EX stalls.
module alu_div_restoring
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  alu_div_restoring_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r, state_nxt_s;
  logic [WIDTH:0]   rem_r, rem_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [WIDTH-1:0] d_r, d_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] quot_r, quot_nxt_s;
  logic [WIDTH-1:0] remo_r, remo_nxt_s;
  logic             dbz_r, dbz_nxt_s;
  logic             busy_r, done_r;

  logic [WIDTH:0]   trial_a_s, trial_b_s, diff_s;
  logic             borrow_s;

  // Shift R left and bring in the next dividend bit; R's MSB is always 0 between iterations.
  assign trial_a_s = (rem_r << 1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};
  assign trial_b_s = {1'b0, d_r};

  sub_nbit #(.WIDTH(WIDTH + 1)) u_sub (
    .a    (trial_a_s),
    .b    (trial_b_s),
    .diff (diff_s),
    .bout (borrow_s)
  );

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    q_nxt_s     = q_r;
    d_nxt_s     = d_r;
    cnt_nxt_s   = cnt_r;
    quot_nxt_s  = quot_r;
    remo_nxt_s  = remo_r;
    dbz_nxt_s   = dbz_r;

    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.divisor != {WIDTH{1'b0}}) begin
            rem_nxt_s   = {(WIDTH + 1){1'b0}};
            q_nxt_s     = bus.dividend;
            d_nxt_s     = bus.divisor;
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = RUN;
          end else begin
            quot_nxt_s  = {WIDTH{1'b1}};
            remo_nxt_s  = bus.dividend;
            dbz_nxt_s   = 1'b1;
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!borrow_s) begin
          rem_nxt_s = diff_s;
          q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          rem_nxt_s = trial_a_s;
          q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
        end
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
          quot_nxt_s  = q_nxt_s;
          remo_nxt_s  = rem_nxt_s[WIDTH-1:0];
          dbz_nxt_s   = 1'b0;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      rem_r   <= {(WIDTH + 1){1'b0}};
      q_r     <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      quot_r  <= {WIDTH{1'b0}};
      remo_r  <= {WIDTH{1'b0}};
      dbz_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      q_r     <= q_nxt_s;
      d_r     <= d_nxt_s;
      cnt_r   <= cnt_nxt_s;
      quot_r  <= quot_nxt_s;
      remo_r  <= remo_nxt_s;
      dbz_r   <= dbz_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = remo_r;
  assign bus.div_by_zero = dbz_r;
endmodule
